// File: rtl/imm_ext_pipe.sv
// RV32I immediate extender with a valid/ready front end and a DEPTH-entry result FIFO.
// Decodes the format from the opcode or an explicit ImmSrc override and flags illegal encodings.
module imm_ext_pipe #(
   parameter int unsigned D_WIDTH = 32,
   parameter int unsigned DEPTH   = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        instr,
   input  logic [2:0]         ImmSrc,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [D_WIDTH-1:0] ImmExt,
   output logic [2:0]         ImmFmt,
   output logic               illegal,
   output logic [15:0]        illegal_cnt
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   localparam logic [2:0] FmtNone  = 3'd0;
   localparam logic [2:0] FmtI     = 3'd1;
   localparam logic [2:0] FmtS     = 3'd2;
   localparam logic [2:0] FmtB     = 3'd3;
   localparam logic [2:0] FmtU     = 3'd4;
   localparam logic [2:0] FmtJ     = 3'd5;
   localparam logic [2:0] FmtShamt = 3'd6;
   localparam logic [2:0] FmtZimm  = 3'd7;

   logic [2:0]         fmt_c;
   logic               ill_c;
   logic [31:0]        imm32_c;
   logic [D_WIDTH-1:0] imm_c;

   logic [D_WIDTH-1:0] mem_imm [DEPTH];
   logic [2:0]         mem_fmt [DEPTH];
   logic               mem_ill [DEPTH];

   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic [15:0]   cnt_q;
   logic          push, pop;

   always_comb begin
      fmt_c = FmtNone;
      ill_c = 1'b0;
      if (ImmSrc != 3'b000) begin
         fmt_c = ImmSrc;
      end else if (instr[1:0] != 2'b11) begin
         ill_c = 1'b1;
      end else begin
         case (instr[6:0])
            7'b0110111, 7'b0010111: fmt_c = FmtU;
            7'b0010011: fmt_c = (instr[13:12] == 2'b01) ? FmtShamt : FmtI;
            7'b0000011, 7'b1100111: fmt_c = FmtI;
            7'b1110011: fmt_c = instr[14] ? FmtZimm : FmtI;
            7'b0100011: fmt_c = FmtS;
            7'b1100011: fmt_c = FmtB;
            7'b1101111: fmt_c = FmtJ;
            7'b0110011: fmt_c = FmtNone;
            default:    ill_c = 1'b1;
         endcase
      end
   end

   // SHAMT/ZIMM have a clear MSB in imm32_c, so one sign-replication covers every format.
   always_comb begin
      imm32_c = '0;
      case (fmt_c)
         FmtI:     imm32_c = {{20{instr[31]}}, instr[31:20]};
         FmtS:     imm32_c = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FmtB:     imm32_c = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
         FmtU:     imm32_c = {instr[31:12], 12'b0};
         FmtJ:     imm32_c = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
         FmtShamt: imm32_c = {27'b0, instr[24:20]};
         FmtZimm:  imm32_c = {27'b0, instr[19:15]};
         default:  imm32_c = '0;
      endcase
      imm_c        = {D_WIDTH{imm32_c[31]}};
      imm_c[31:0]  = imm32_c;
   end

   assign in_ready  = (count_q != CW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_imm[wr_ptr_q] <= imm_c;
         mem_fmt[wr_ptr_q] <= fmt_c;
         mem_ill[wr_ptr_q] <= ill_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         if (push && !pop)      count_q <= count_q + CW'(1);
         else if (pop && !push) count_q <= count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (push && ill_c && (cnt_q != 16'hFFFF)) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign ImmExt      = out_valid ? mem_imm[rd_ptr_q] : '0;
   assign ImmFmt      = out_valid ? mem_fmt[rd_ptr_q] : 3'd0;
   assign illegal     = out_valid ? mem_ill[rd_ptr_q] : 1'b0;
   assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: 32- and 64-bit instances share stimulus and are checked against a
// queue-based model every cycle, plus hand-computed directed vectors.
module tb_imm_ext_pipe;

   localparam int unsigned DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, flush, out_ready;
   logic [31:0] instr;
   logic [2:0]  src;

   logic        rdy32, v32, ill32, rdy64, v64, ill64;
   logic [31:0] imm32;
   logic [63:0] imm64;
   logic [2:0]  fmt32, fmt64;
   logic [15:0] cnt32, cnt64;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   imm_ext_pipe #(.D_WIDTH(32), .DEPTH(DEPTH)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32), .instr(instr),
      .ImmSrc(src), .flush(flush), .out_valid(v32), .out_ready(out_ready), .ImmExt(imm32),
      .ImmFmt(fmt32), .illegal(ill32), .illegal_cnt(cnt32)
   );

   imm_ext_pipe #(.D_WIDTH(64), .DEPTH(DEPTH)) dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64), .instr(instr),
      .ImmSrc(src), .flush(flush), .out_valid(v64), .out_ready(out_ready), .ImmExt(imm64),
      .ImmFmt(fmt64), .illegal(ill64), .illegal_cnt(cnt64)
   );

   typedef struct packed {
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic        ill;
   } ent_t;

   ent_t        q[$];
   logic [15:0] mcnt;

   // Sign-extend the low 'bits' of v to 64 bits using signed arithmetic shifts.
   function automatic logic [63:0] sx(input logic [31:0] v, input int bits);
      int     t;
      longint r;
      t = int'(v << (32 - bits));
      r = longint'(t >>> (32 - bits));
      return r;
   endfunction

   function automatic ent_t mdec(input logic [31:0] i, input logic [2:0] s);
      ent_t e;
      e = '0;
      if (s != 3'd0) e.fmt = s;
      else if (i[1:0] != 2'b11) e.ill = 1'b1;
      else begin
         case (i[6:0])
            7'h37, 7'h17: e.fmt = 3'd4;
            7'h13:        e.fmt = (i[14:12] == 3'd1 || i[14:12] == 3'd5) ? 3'd6 : 3'd1;
            7'h03, 7'h67: e.fmt = 3'd1;
            7'h73:        e.fmt = i[14] ? 3'd7 : 3'd1;
            7'h23:        e.fmt = 3'd2;
            7'h63:        e.fmt = 3'd3;
            7'h6F:        e.fmt = 3'd5;
            7'h33:        e.fmt = 3'd0;
            default:      e.ill = 1'b1;
         endcase
      end
      case (e.fmt)
         3'd1: e.imm = sx(i >> 20, 12);
         3'd2: e.imm = sx(((i >> 25) << 5) | ((i >> 7) & 32'h1F), 12);
         3'd3: e.imm = sx((((i >> 31) & 1) << 12) | (((i >> 7) & 1) << 11) |
                          (((i >> 25) & 32'h3F) << 5) | (((i >> 8) & 32'hF) << 1), 13);
         3'd4: e.imm = sx(i & 32'hFFFF_F000, 32);
         3'd5: e.imm = sx((((i >> 31) & 1) << 20) | (i & 32'h000F_F000) |
                          (((i >> 20) & 1) << 11) | (((i >> 21) & 32'h3FF) << 1), 21);
         3'd6: e.imm = 64'((i >> 20) & 32'h1F);
         3'd7: e.imm = 64'((i >> 15) & 32'h1F);
         default: e.imm = '0;
      endcase
      return e;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         mcnt <= '0;
      end else if (flush) begin
         q.delete();
      end else begin : mdl
         automatic bit   do_pop  = (q.size() != 0) && out_ready;
         automatic bit   do_push = in_valid && (q.size() != DEPTH);
         automatic ent_t e       = mdec(instr, src);
         if (do_pop) void'(q.pop_front());
         if (do_push) begin
            q.push_back(e);
            if (e.ill && mcnt != 16'hFFFF) mcnt <= mcnt + 16'd1;
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 40) $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin : cmp
      automatic ent_t h  = (q.size() != 0) ? q[0] : '0;
      automatic bit   ev = (q.size() != 0);
      automatic bit   er = (q.size() != DEPTH);
      chk("cyc_valid32", 64'(v32), 64'(ev));
      chk("cyc_valid64", 64'(v64), 64'(ev));
      chk("cyc_ready32", 64'(rdy32), 64'(er));
      chk("cyc_ready64", 64'(rdy64), 64'(er));
      chk("cyc_imm32", 64'(imm32), 64'(h.imm[31:0]));
      chk("cyc_imm64", imm64, h.imm);
      chk("cyc_fmt", 64'({fmt32, fmt64}), 64'({h.fmt, h.fmt}));
      chk("cyc_ill", 64'({ill32, ill64}), 64'({h.ill, h.ill}));
      chk("cyc_cnt", 64'({cnt32, cnt64}), 64'({mcnt, mcnt}));
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Push one instruction into an empty FIFO with out_ready=1 and check the head next cycle.
   task automatic send_chk(input logic [31:0] ins, input logic [2:0] s, input logic [63:0] exp,
                           input logic [2:0] f, input logic il);
      instr = ins; src = s; in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      chk($sformatf("valid_%h", ins), 64'(v32), 64'd1);
      chk($sformatf("imm64_%h", ins), imm64, exp);
      chk($sformatf("imm32_%h", ins), 64'(imm32), 64'(exp[31:0]));
      chk($sformatf("fmt_%h", ins), 64'(fmt32), 64'(f));
      chk($sformatf("ill_%h", ins), 64'(ill32), 64'(il));
      cyc();
   endtask

   task automatic rst_chk(input string tag);
      chk({tag, "_valid"}, 64'({v32, v64}), 64'd0);
      chk({tag, "_ready"}, 64'({rdy32, rdy64}), 64'd3);
      chk({tag, "_imm"}, imm64 | 64'(imm32), 64'd0);
      chk({tag, "_fmt_ill"}, 64'({fmt32, ill32, fmt64, ill64}), 64'd0);
      chk({tag, "_cnt"}, 64'({cnt32, cnt64}), 64'd0);
   endtask

   initial begin
      in_valid = 1'b0; instr = '0; src = '0; flush = 1'b0; out_ready = 1'b0; rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #3 rst_chk("reset");
      cyc(); cyc();
      rst_n = 1'b1;
      cyc();

      out_ready = 1'b1;
      send_chk(32'hFFF00093, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);

      // Illegal head followed by backpressure with DEPTH=2.
      out_ready = 1'b0;
      instr = 32'h0000_0000; src = 3'd0; in_valid = 1'b1;
      cyc();
      instr = 32'hFFF00093;
      cyc();
      instr = 32'h0050_0113;
      chk("ill_head", 64'(ill32), 64'd1);
      chk("ill_imm_fmt", 64'(imm32) | 64'(fmt32), 64'd0);
      chk("ill_cnt", 64'(cnt32), 64'd1);
      chk("full_ready", 64'(rdy32), 64'd0);
      cyc(); cyc();
      chk("held_ready", 64'(rdy32), 64'd0);
      chk("held_head", 64'(ill32), 64'd1);
      out_ready = 1'b1;
      cyc();
      chk("order_2nd", 64'(imm32), 64'hFFFF_FFFF);
      chk("order_2nd_ready", 64'(rdy32), 64'd1);
      cyc();
      in_valid = 1'b0;
      chk("pushpop_valid", 64'(v32), 64'd1);
      chk("pushpop_ready", 64'(rdy32), 64'd1);
      chk("order_3rd", 64'(imm32), 64'd5);
      cyc();
      chk("drained", 64'(v32), 64'd0);

      // Flush with two queued entries and an illegal input presented.
      out_ready = 1'b0;
      instr = 32'hFFF00093; in_valid = 1'b1;
      cyc();
      instr = 32'h0050_0113;
      cyc();
      instr = 32'h0000_0000; flush = 1'b1;
      cyc();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_valid", 64'(v32), 64'd0);
      chk("flush_ready", 64'(rdy32), 64'd1);
      chk("flush_cnt", 64'(cnt32), 64'd1);
      cyc();

      out_ready = 1'b1;
      send_chk(32'hFE000EE3, 3'd0, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0);
      send_chk(32'h0010006F, 3'd0, 64'h0000_0000_0000_0800, 3'd5, 1'b0);
      send_chk(32'h40515093, 3'd0, 64'h5, 3'd6, 1'b0);
      send_chk(32'h00F09093, 3'd0, 64'hF, 3'd6, 1'b0);
      send_chk(32'h800000B7, 3'd0, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0);
      send_chk(32'hFE112E23, 3'd0, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0);
      send_chk(32'h34011073, 3'd0, 64'h340, 3'd1, 1'b0);
      send_chk(32'h3402D073, 3'd0, 64'h5, 3'd7, 1'b0);
      send_chk(32'h002081B3, 3'd0, 64'h0, 3'd0, 1'b0);
      send_chk(32'h0000007F, 3'd0, 64'h0, 3'd0, 1'b1);
      send_chk(32'hFFFFFFFF, 3'd7, 64'h1F, 3'd7, 1'b0);
      send_chk(32'h00000F80, 3'd2, 64'h1F, 3'd2, 1'b0);
      send_chk(32'h0000007F, 3'd4, 64'h0, 3'd4, 1'b0);
      chk("cnt_after_table", 64'(cnt32), 64'd2);

      // Mixed traffic; the per-cycle comparison does the checking here.
      for (int k = 0; k < 80; k++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         instr     = $urandom;
         src       = ($urandom_range(0, 1) != 0) ? 3'd0 : 3'($urandom_range(0, 7));
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         cyc();
      end
      flush = 1'b0;

      out_ready = 1'b1; in_valid = 1'b1; instr = 32'h0000_0000; src = 3'd0;
      repeat (65536) cyc();
      in_valid = 1'b0;
      chk("cnt_saturated", 64'(cnt32), 64'hFFFF);
      chk("cnt_saturated64", 64'(cnt64), 64'hFFFF);
      cyc(); cyc();

      // Asynchronous reset with entries queued.
      out_ready = 1'b0; instr = 32'hFFF00093; in_valid = 1'b1;
      cyc(); cyc();
      in_valid = 1'b0;
      rst_n = 1'b0;
      #2 rst_chk("midreset");
      cyc();
      rst_n = 1'b1;
      cyc();
      out_ready = 1'b1;
      send_chk(32'h800000B7, 3'd0, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0);
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Pipelined, parametrised immediate extender for the RV32I core's decode path. It accepts 32-bit instructions over a valid/ready handshake and decodes the immediate format either from the opcode itself or from an explicit `ImmSrc` override. Every RV32I format is supported: I, S, B, U, J, plus shift-amount and CSR zimm. The immediate is sign- or zero-extended to `D_WIDTH`, and results are queued in a `DEPTH`-entry output FIFO with an illegal-encoding flag and a saturating illegal counter.

## Interface
- `D_WIDTH`, 32: output immediate width; must be ≥ 32 (64 for RV64 reuse).
- `DEPTH`, 2: output FIFO entries; power of two, ≥ 2.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `instr`/`ImmSrc` valid.
- `in_ready`  out  1  block can accept; `in_ready = (count != DEPTH)`.
- `instr`  in  32  instruction word.
- `ImmSrc`  in  3  000 auto-decode, 001 I, 010 S, 011 B, 100 U, 101 J, 110 SHAMT, 111 ZIMM.
- `flush`  in  1  synchronous clear of FIFO contents.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer takes head.
- `ImmExt`  out  D_WIDTH  extended immediate at head.
- `ImmFmt`  out  3  format at head: 0 R/none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM.
- `illegal`  out  1  head entry was an unrecognised encoding.
- `illegal_cnt`  out  16  count of accepted illegal instructions; saturates at 0xFFFF.

## Operation
- Accept occurs when `in_valid && in_ready && !flush`. On accept, the format and immediate are computed combinationally from `instr` and written to the FIFO tail.
- Auto-decode (`ImmSrc=000`) uses opcode `instr[6:0]`:
  - 0110111, 0010111 → U.
  - 0010011 → I. Exception: when funct3 is 001 or 101 the format is SHAMT.
  - 0000011, 1100111 → I.
  - 1110011 → I when funct3[2]=0; ZIMM when funct3[2]=1.
  - 0100011 → S.
  - 1100011 → B.
  - 1101111 → J.
  - 0110011 → R (imm 0, not illegal).
  - Any other opcode, or `instr[1:0] != 11` → illegal=1, fmt 0, imm 0.
- Explicit `ImmSrc` (001–111) forces the format and never sets `illegal`.
- Extension rules. `sext(x)` means replicate `instr[31]` up to `D_WIDTH`.
  - I: `sext(instr[31:20])`.
  - S: `sext({instr[31:25], instr[11:7]})`.
  - B: `sext({instr[31], instr[7], instr[30:25], instr[11:8], 0})`.
  - U: `sext({instr[31:12], 12'b0})`.
  - J: `sext({instr[31], instr[19:12], instr[20], instr[30:21], 0})`.
  - SHAMT: zero-extend `instr[24:20]`; bit 30 (arith select) is excluded.
  - ZIMM: zero-extend `instr[19:15]`.
- FIFO:
  - Circular buffer with read/write pointers that wrap at `DEPTH`; `count` is 0..DEPTH.
  - Pop occurs when `out_valid && out_ready && !flush`.
  - Simultaneous push and pop leaves `count` unchanged and is legal at any non-full count.
  - When full, `in_ready=0` regardless of `out_ready`; there is no same-cycle pass-through.
- `flush` takes priority over push and pop in the same cycle. It zeroes pointers and `count`, and drops any input presented that cycle. It does not touch `illegal_cnt`.
- `illegal_cnt` increments on each accept whose entry has illegal=1, holds at 0xFFFF, and is cleared only by `rst_n`.
- When the FIFO is empty, `out_valid=0` and `ImmExt`, `ImmFmt`, `illegal` are forced to 0.

## Timing
- Reset (`rst_n`=0, asynchronous) sets:
  - `count=0`, pointers 0, `illegal_cnt=0`.
  - `out_valid=0`, `ImmExt=0`, `ImmFmt=0`, `illegal=0`.
  - `in_ready=1`.
- Reset asserted mid-operation discards all queued entries immediately, without waiting for a clock edge.
- Latency: an instruction accepted at edge N appears at the head (`out_valid=1`) in the cycle after edge N when the FIFO was empty. Otherwise it appears after the preceding entries have popped.
- Throughput is one instruction per cycle sustained when `out_ready=1`.
- The head holds stable while `out_valid && !out_ready`.
- `in_ready` depends only on registered `count`; it is never combinational on `out_ready` or `in_valid`.

## Test plan
- Auto-decode I: `addi x1,x0,-1` (0xFFF00093) → `ImmExt`=0xFFFFFFFF, fmt 1, illegal 0, `out_valid` one cycle after accept.
- B and J: 0xFE000EE3 (beq −4) → 0xFFFFFFFC, fmt 3. 0x0010006F (jal +2048) → 0x00000800, fmt 5.
- Width and SHAMT:
  - With `D_WIDTH`=64, `lui` 0x800000B7 → 0xFFFFFFFF80000000, fmt 4.
  - 0x40515093 (srai x1,x2,5) → 0x5, fmt 6.
- Illegal: push 0x00000000, then a valid instruction → first head illegal=1, imm 0, fmt 0; `illegal_cnt`=1. Force 65536 illegal instructions → `illegal_cnt` stays at 0xFFFF.
- Backpressure, `DEPTH`=2, `out_ready=0`:
  - Three back-to-back pushes → `in_ready` drops after the second; the third is held, not lost.
  - Raise `out_ready` → entries emerge in order with no duplicate.
  - Simultaneous push+pop at count 1 keeps count 1.
- Flush and reset: `flush` asserted with count 2 and `in_valid=1` → next cycle `out_valid=0`, `in_ready=1`, the input is dropped, and `illegal_cnt` is unchanged. `rst_n` pulsed low mid-stream → all outputs return to reset values before the next edge.
